demux_subtrator: RTL

Bit-serial subtractor with a demultiplexed, registered result. It accepts a sum and the A operand, then recovers the second operand as `entrada_soma - entradaA`, one bit per clock, LSB first. The result is steered to the B or C output selected by `sel_demux`. The block is the inverse path of the A + mux(B, C) adder datapath: fed that datapath's result and its A input, it reproduces B or C for self-checking and round-trip tests in the lab designs.

---
 rtl/demux_subtrator_if.sv | 33 +++
 rtl/demux_subtrator.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/demux_subtrator_if.sv
// demux_subtrator_if
//   Bundles the start/operand/result signals of the bit-serial demux
//   subtractor so that the bench and the design share one connection.
//
//   master modport (stimulus side):
//     drives   inicio, entrada_soma, entradaA, sel_demux
//     observes pronto, saidaB, saidaC, valido_B, valido_C, emprestimo
//   slave modport (demux_subtrator):
//     the same signals with the directions reversed.
interface demux_subtrator_if #(
  parameter int WIDTH = 4
);
  logic             inicio;
  logic [WIDTH-1:0] entrada_soma;
  logic [WIDTH-1:0] entradaA;
  logic             sel_demux;
  logic             pronto;
  logic [WIDTH-1:0] saidaB;
  logic [WIDTH-1:0] saidaC;
  logic             valido_B;
  logic             valido_C;
  logic             emprestimo;

  modport master (
    output inicio, entrada_soma, entradaA, sel_demux,
    input  pronto, saidaB, saidaC, valido_B, valido_C, emprestimo
  );

  modport slave (
    input  inicio, entrada_soma, entradaA, sel_demux,
    output pronto, saidaB, saidaC, valido_B, valido_C, emprestimo
  );
endinterface

// File: rtl/demux_subtrator.sv
// demux_subtrator
//   Bit-serial subtractor whose result is steered to one of two registered
//   outputs. It computes entrada_soma - entradaA (mod 2^WIDTH) one bit per
//   clock, LSB first, and writes the difference to saidaB (sel_demux=0) or
//   saidaC (sel_demux=1). It undoes the A + mux(B, C) adder datapath.
//
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous, active-high reset
//     bus  - demux_subtrator_if.slave:
//              inicio        start request, taken only while pronto=1
//              entrada_soma  minuend
//              entradaA      subtrahend
//              sel_demux     0 -> saidaB, 1 -> saidaC
//              pronto        idle, ready for inicio
//              saidaB/saidaC last result steered to each output (held)
//              valido_B/C    one-cycle pulse when the matching output updates
//              emprestimo    final borrow (entrada_soma < entradaA)
//
//   Timing: inicio accepted at E0, bits processed at E1..E(WIDTH),
//   results visible after E(WIDTH+1); next start accepted at E(WIDTH+2).
module demux_subtrator #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  demux_subtrator_if.slave bus
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    CALCULA = 2'd1,
    CONCLUI = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] soma_q, soma_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             sel_q, sel_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             bw_q, bw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [WIDTH-1:0] saida_b_q, saida_b_d;
  logic [WIDTH-1:0] saida_c_q, saida_c_d;
  logic             valido_b_q, valido_b_d;
  logic             valido_c_q, valido_c_d;
  logic             emprestimo_q, emprestimo_d;
  logic             pronto_q, pronto_d;
  logic             diff_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= OCIOSO;
      soma_q       <= '0;
      a_q          <= '0;
      sel_q        <= 1'b0;
      cnt_q        <= '0;
      bw_q         <= 1'b0;
      diff_q       <= '0;
      saida_b_q    <= '0;
      saida_c_q    <= '0;
      valido_b_q   <= 1'b0;
      valido_c_q   <= 1'b0;
      emprestimo_q <= 1'b0;
      pronto_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      soma_q       <= soma_d;
      a_q          <= a_d;
      sel_q        <= sel_d;
      cnt_q        <= cnt_d;
      bw_q         <= bw_d;
      diff_q       <= diff_d;
      saida_b_q    <= saida_b_d;
      saida_c_q    <= saida_c_d;
      valido_b_q   <= valido_b_d;
      valido_c_q   <= valido_c_d;
      emprestimo_q <= emprestimo_d;
      pronto_q     <= pronto_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    soma_d       = soma_q;
    a_d          = a_q;
    sel_d        = sel_q;
    cnt_d        = cnt_q;
    bw_d         = bw_q;
    diff_d       = diff_q;
    saida_b_d    = saida_b_q;
    saida_c_d    = saida_c_q;
    valido_b_d   = 1'b0;
    valido_c_d   = 1'b0;
    emprestimo_d = emprestimo_q;
    pronto_d     = pronto_q;
    diff_bit     = 1'b0;

    case (state_q)
      OCIOSO: begin
        if (bus.inicio) begin
          soma_d   = bus.entrada_soma;
          a_d      = bus.entradaA;
          sel_d    = bus.sel_demux;
          cnt_d    = '0;
          bw_d     = 1'b0;
          pronto_d = 1'b0;
          state_d  = CALCULA;
        end
      end

      CALCULA: begin
        // Operands are shifted right so bit 0 is always the current bit;
        // the difference enters at the MSB so that after WIDTH shifts the
        // first (LSB) result bit has reached position 0.
        diff_bit = soma_q[0] ^ a_q[0] ^ bw_q;
        bw_d     = (~soma_q[0] & a_q[0]) | (~(soma_q[0] ^ a_q[0]) & bw_q);
        diff_d   = {diff_bit, diff_q[WIDTH-1:1]};
        soma_d   = soma_q >> 1;
        a_d      = a_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = CONCLUI;
        end
      end

      CONCLUI: begin
        if (sel_q) begin
          saida_c_d  = diff_q;
          valido_c_d = 1'b1;
        end else begin
          saida_b_d  = diff_q;
          valido_b_d = 1'b1;
        end
        emprestimo_d = bw_q;
        pronto_d     = 1'b1;
        state_d      = OCIOSO;
      end

      default: begin
        state_d  = OCIOSO;
        pronto_d = 1'b1;
      end
    endcase
  end

  assign bus.pronto     = pronto_q;
  assign bus.saidaB     = saida_b_q;
  assign bus.saidaC     = saida_c_q;
  assign bus.valido_B   = valido_b_q;
  assign bus.valido_C   = valido_c_q;
  assign bus.emprestimo = emprestimo_q;

endmodule
